// File: rtl/core_writeback_arbiter_if.sv
// Writeback bus between execution units and the arbiter.
// EUs drive the master side; the arbiter sits on the slave side.
interface core_writeback_arbiter_if #(
  parameter int NUM_REQ   = 5,
  parameter int NUM_PORTS = 2,
  parameter int REG_BITS  = 4,
  parameter int DATA_BITS = 32
);
  logic [NUM_REQ-1:0]             in_valid;
  logic [NUM_REQ*REG_BITS-1:0]    in_rd;
  logic [NUM_REQ*DATA_BITS-1:0]   in_value;
  logic [NUM_REQ-1:0]             in_ready;
  logic [NUM_PORTS-1:0]           wr_en;
  logic [NUM_PORTS*REG_BITS-1:0]  wr_rd;
  logic [NUM_PORTS*DATA_BITS-1:0] wr_value;
  logic [(2**REG_BITS)-1:0]       pend_mask;
  logic                           wb_stall_branch;

  modport master (
    output in_valid,
    output in_rd,
    output in_value,
    input  in_ready,
    input  wr_en,
    input  wr_rd,
    input  wr_value,
    input  pend_mask,
    input  wb_stall_branch
  );

  modport slave (
    input  in_valid,
    input  in_rd,
    input  in_value,
    output in_ready,
    output wr_en,
    output wr_rd,
    output wr_value,
    output pend_mask,
    output wb_stall_branch
  );
endinterface

// File: rtl/core_writeback_arbiter.sv
// Round-robin writeback arbiter: per-EU holding buffers drained
// onto registered register-file write ports.
module core_writeback_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int NUM_PORTS = 2,
  parameter int REG_BITS  = 4,
  parameter int DATA_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  core_writeback_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int MSK_W = 2**REG_BITS;

  logic [NUM_REQ-1:0]   buf_valid;
  logic [REG_BITS-1:0]  buf_rd    [NUM_REQ];
  logic [DATA_BITS-1:0] buf_value [NUM_REQ];
  logic [PTR_W-1:0]     rr_ptr;

  logic [NUM_REQ-1:0]   grant;
  logic [1:0]           win_vld;
  logic [PTR_W-1:0]     win_idx [2];
  logic [PTR_W-1:0]     last_idx;
  logic [PTR_W-1:0]     next_ptr;
  logic [PTR_W:0]       scan_sum;
  logic [PTR_W-1:0]     scan_idx;

  logic [NUM_PORTS-1:0]           wr_en_q;
  logic [NUM_PORTS*REG_BITS-1:0]  wr_rd_q;
  logic [NUM_PORTS*DATA_BITS-1:0] wr_value_q;
  logic [MSK_W-1:0]               pend;

  // Scan from rr_ptr; port 1 takes the next entry with a different rd.
  always_comb begin
    grant      = '0;
    win_vld    = '0;
    win_idx[0] = '0;
    win_idx[1] = '0;
    last_idx   = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ))
        scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      scan_idx = scan_sum[PTR_W-1:0];
      if (buf_valid[scan_idx]) begin
        if (!win_vld[0]) begin
          win_vld[0]      = 1'b1;
          win_idx[0]      = scan_idx;
          grant[scan_idx] = 1'b1;
          last_idx        = scan_idx;
        end else if (NUM_PORTS > 1 && !win_vld[1] &&
                     buf_rd[scan_idx] != buf_rd[win_idx[0]]) begin
          win_vld[1]      = 1'b1;
          win_idx[1]      = scan_idx;
          grant[scan_idx] = 1'b1;
          last_idx        = scan_idx;
        end
      end
    end
  end

  assign next_ptr = (last_idx == PTR_W'(NUM_REQ-1)) ?
                    '0 : last_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_rd[i]    <= '0;
        buf_value[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.in_valid[i] && bus.in_ready[i]) begin
          buf_valid[i] <= 1'b1;
          buf_rd[i]    <= bus.in_rd[i*REG_BITS +: REG_BITS];
          buf_value[i] <= bus.in_value[i*DATA_BITS +: DATA_BITS];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
      if (|grant)
        rr_ptr <= next_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q    <= '0;
      wr_rd_q    <= '0;
      wr_value_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_en_q[p] <= win_vld[p];
        if (win_vld[p]) begin
          wr_rd_q[p*REG_BITS +: REG_BITS] <=
            buf_rd[win_idx[p]];
          wr_value_q[p*DATA_BITS +: DATA_BITS] <=
            buf_value[win_idx[p]];
        end
      end
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (buf_valid[i])
        pend[buf_rd[i]] = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++)
      if (wr_en_q[p])
        pend[wr_rd_q[p*REG_BITS +: REG_BITS]] = 1'b1;
  end

  assign bus.in_ready        = ~buf_valid | grant;
  assign bus.wb_stall_branch = ~bus.in_ready[2];
  assign bus.wr_en           = wr_en_q;
  assign bus.wr_rd           = wr_rd_q;
  assign bus.wr_value        = wr_value_q;
  assign bus.pend_mask       = pend;

endmodule

// File: tb/tb_core_writeback_arbiter.sv
// Directed self-checking bench for core_writeback_arbiter.
// Inputs change #1 after posedge; outputs are sampled there too.
module tb_core_writeback_arbiter;
  localparam int NR = 5;
  localparam int NP = 2;
  localparam int RB = 4;
  localparam int DB = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  core_writeback_arbiter_if #(
    .NUM_REQ(NR), .NUM_PORTS(NP),
    .REG_BITS(RB), .DATA_BITS(DB)
  ) bus ();

  core_writeback_arbiter #(
    .NUM_REQ(NR), .NUM_PORTS(NP),
    .REG_BITS(RB), .DATA_BITS(DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int eu, input int rd,
                      input logic [31:0] val);
    bus.in_valid[eu] = 1'b1;
    bus.in_rd[eu*RB +: RB] = RB'(rd);
    bus.in_value[eu*DB +: DB] = val;
  endtask

  task automatic drop(input int eu);
    bus.in_valid[eu] = 1'b0;
  endtask

  task automatic clr();
    bus.in_valid = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [RB-1:0] wrd(input int p);
    return bus.wr_rd[p*RB +: RB];
  endfunction

  function automatic logic [DB-1:0] wval(input int p);
    return bus.wr_value[p*DB +: DB];
  endfunction

  int stall_cycles;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = '0;
    bus.in_rd = '0;
    bus.in_value = '0;
    #12;
    check("rst_wr_en", 64'(bus.wr_en), 64'h0);
    check("rst_pend", 64'(bus.pend_mask), 64'h0);
    check("rst_ready", 64'(bus.in_ready), 64'h1f);
    check("rst_stall", 64'(bus.wb_stall_branch), 64'h0);
    check("rst_rr", 64'(dut.rr_ptr), 64'h0);
    rst_n = 1'b1;
    tick();

    // single writeback
    send(1, 5, 32'hDEADBEEF);
    tick();
    clr();
    check("s_pend1", 64'(bus.pend_mask), 64'h0020);
    check("s_en0", 64'(bus.wr_en), 64'h0);
    tick();
    check("s_en1", 64'(bus.wr_en), 64'h1);
    check("s_rd", 64'(wrd(0)), 64'd5);
    check("s_val", 64'(wval(0)), 64'hDEADBEEF);
    check("s_pend2", 64'(bus.pend_mask), 64'h0020);
    tick();
    check("s_en2", 64'(bus.wr_en), 64'h0);
    check("s_pend3", 64'(bus.pend_mask), 64'h0);
    check("s_rr", 64'(dut.rr_ptr), 64'd2);

    // full contention from rr_ptr=0
    pulse_reset();
    for (int i = 0; i < NR; i++)
      send(i, i + 1, 32'h100 + i);
    tick();
    clr();
    check("fc_ready", 64'(bus.in_ready), 64'h03);
    check("fc_pend", 64'(bus.pend_mask), 64'h003e);
    tick();
    check("fc1_en", 64'(bus.wr_en), 64'h3);
    check("fc1_rd0", 64'(wrd(0)), 64'd1);
    check("fc1_rd1", 64'(wrd(1)), 64'd2);
    check("fc1_rr", 64'(dut.rr_ptr), 64'd2);
    tick();
    check("fc2_en", 64'(bus.wr_en), 64'h3);
    check("fc2_rd0", 64'(wrd(0)), 64'd3);
    check("fc2_rd1", 64'(wrd(1)), 64'd4);
    check("fc2_v1", 64'(wval(1)), 64'h103);
    check("fc2_rr", 64'(dut.rr_ptr), 64'd4);
    tick();
    check("fc3_en", 64'(bus.wr_en), 64'h1);
    check("fc3_rd0", 64'(wrd(0)), 64'd5);
    check("fc3_v0", 64'(wval(0)), 64'h104);
    check("fc3_rr", 64'(dut.rr_ptr), 64'd0);
    tick();
    check("fc4_en", 64'(bus.wr_en), 64'h0);

    // same-rd collision
    send(0, 7, 32'hAAAA0000);
    send(1, 7, 32'hBBBB1111);
    tick();
    clr();
    check("co_ready", 64'(bus.in_ready), 64'h1d);
    tick();
    check("co1_en", 64'(bus.wr_en), 64'h1);
    check("co1_rd", 64'(wrd(0)), 64'd7);
    check("co1_val", 64'(wval(0)), 64'hAAAA0000);
    check("co1_ready", 64'(bus.in_ready), 64'h1f);
    check("co1_pend", 64'(bus.pend_mask), 64'h0080);
    tick();
    check("co2_en", 64'(bus.wr_en), 64'h1);
    check("co2_val", 64'(wval(0)), 64'hBBBB1111);
    check("co2_rr", 64'(dut.rr_ptr), 64'd2);
    tick();
    check("co3_en", 64'(bus.wr_en), 64'h0);

    // branch backpressure vs refilling EUs 0 and 1
    pulse_reset();
    stall_cycles = 0;
    send(0, 1, 32'h10);
    send(1, 2, 32'h20);
    send(2, 3, 32'h30);
    tick();
    drop(2);
    send(0, 4, 32'h40);
    send(1, 5, 32'h50);
    if (bus.wb_stall_branch) stall_cycles++;
    check("bp_stall1", 64'(bus.wb_stall_branch), 64'h1);
    tick();
    clr();
    if (bus.wb_stall_branch) stall_cycles++;
    check("bp_stall2", 64'(bus.wb_stall_branch), 64'h0);
    check("bp1_rd0", 64'(wrd(0)), 64'd1);
    check("bp1_rd1", 64'(wrd(1)), 64'd2);
    tick();
    check("bp2_en", 64'(bus.wr_en), 64'h3);
    check("bp2_rd0", 64'(wrd(0)), 64'd3);
    check("bp2_v0", 64'(wval(0)), 64'h30);
    check("bp2_rd1", 64'(wrd(1)), 64'd4);
    tick();
    check("bp3_en", 64'(bus.wr_en), 64'h1);
    check("bp3_rd0", 64'(wrd(0)), 64'd5);
    check("bp_ncyc", 64'(stall_cycles <= 2), 64'h1);
    tick();

    // back-to-back streaming on EU3
    for (int i = 0; i < 6; i++) begin
      send(3, i + 1, 32'h300 + i);
      tick();
      check("st_ready", 64'(bus.in_ready[3]), 64'h1);
      if (i > 0) begin
        check("st_en", 64'(bus.wr_en[0]), 64'h1);
        check("st_rd", 64'(wrd(0)), 64'(i));
      end
    end
    clr();
    tick();
    check("st_last", 64'(wrd(0)), 64'd6);
    tick();
    check("st_idle", 64'(bus.wr_en), 64'h0);

    // reset mid-traffic with buffers 0 and 3 full
    send(1, 2, 32'h22);
    tick();
    clr();
    send(0, 9, 32'h99);
    send(3, 10, 32'hAA);
    tick();
    clr();
    check("mr_pre_en", 64'(bus.wr_en), 64'h1);
    rst_n = 1'b0;
    #1;
    check("mr_en", 64'(bus.wr_en), 64'h0);
    check("mr_pend", 64'(bus.pend_mask), 64'h0);
    check("mr_ready", 64'(bus.in_ready), 64'h1f);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_noen", 64'(bus.wr_en), 64'h0);
      check("mr_nopend", 64'(bus.pend_mask), 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_writeback_arbiter.md
Name: core_writeback_arbiter

Overview:
- Shares the register-file write ports between all execution units: alu_a, alu_b, branch, mul, ldst.
- Each EU pushes its result into a one-entry holding buffer. A round-robin arbiter drains the buffers onto NUM_PORTS registered write ports.
- Exports the register mask of all in-flight writebacks, used as a dispatch hazard mask.
- Exports per-EU backpressure; the branch EU's backpressure is wb_stall_branch.

Parameters:
- NUM_REQ, 5, number of requesting EUs (index 0 alu_a, 1 alu_b, 2 branch, 3 mul, 4 ldst).
- NUM_PORTS, 2, register-file write ports. Legal values 1 or 2.
- REG_BITS, 4, register index width. Masks are 2**REG_BITS = 16 bits (hword).
- DATA_BITS, 32, writeback value width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  NUM_REQ  EU i presents a writeback
- in_rd  in  NUM_REQ*REG_BITS  destination register per EU
- in_value  in  NUM_REQ*DATA_BITS  result per EU
- in_ready  out  NUM_REQ  EU i may hand over this cycle
- wr_en  out  NUM_PORTS  register-file write enable per port (registered)
- wr_rd  out  NUM_PORTS*REG_BITS  write register per port (registered)
- wr_value  out  NUM_PORTS*DATA_BITS  write data per port (registered)
- pend_mask  out  16  one-hot OR of rd for every valid buffer entry and every asserted wr_en port
- wb_stall_branch  out  1  equals !in_ready[2]

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - All buffers invalid; rr_ptr=0.
  - wr_en=0, wr_rd=0, wr_value=0.
  - pend_mask=0, in_ready=all 1, wb_stall_branch=0.
  - Reset mid-operation discards buffered and port-stage writebacks with no write performed.
- Buffers: per EU, buf_valid/buf_rd/buf_value.
  - in_ready[i] = !buf_valid[i] || grant[i]. This is combinational, so a granted entry frees its slot in the same cycle.
  - Accept on in_valid[i] && in_ready[i]: the buffer loads at the clock edge.
  - Handshake: an EU holds valid, rd and value stable until accepted.
  - in_ready does not depend on in_valid.
- Arbitration (combinational over buffered entries only; incoming data is never bypassed):
  - Scan indices rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - The first valid entry wins port 0.
  - The next valid entry whose buf_rd differs from port 0's rd wins port 1.
  - An entry with a same-rd collision is not granted and waits.
- Port stage:
  - At the edge, wr_en[p]<=winner exists; wr_rd/wr_value<=winner's data.
  - Unused ports drive wr_en=0 with wr_rd/wr_value held.
- rr_ptr: at the edge, rr_ptr<=(index of last granted entry + 1) mod NUM_REQ. It is unchanged when nothing is granted.
- Latency:
  - Accept at edge k, then the entry appears on wr_* after edge k+1 when granted.
  - Minimum 1 cycle from buffer load to wr_en. Throughput: one writeback per EU per cycle when uncontended.
- Starvation bound: any buffered entry is granted within NUM_REQ cycles.
- pend_mask:
  - Combinational OR of decoded buf_rd[i] where buf_valid, and decoded wr_rd[p] where wr_en.
  - Bits for registers with no pending write are 0. Duplicate rd values simply OR.
- Boundaries:
  - All NUM_REQ buffers full with NUM_PORTS=2: two grants per cycle, all drained in ceil(NUM_REQ/2) cycles if rds are distinct.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Simultaneous grant and new in_valid on the same EU: the buffer is reloaded at the same edge, with no bubble.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-traffic with buffers 0 and 3 full.
  - Required: wr_en=00, pend_mask=0, in_ready=11111 immediately. After release, no write of the discarded entries ever appears.
- Single writeback:
  - Stimulus: EU1 sends rd=5, value=0xDEADBEEF at edge 0.
  - Required: after edge 1, wr_en=01, wr_rd[0]=5, wr_value[0]=0xDEADBEEF; pend_mask=0x0020 during cycles 1–2, then 0.
- Full contention:
  - Stimulus: all five EUs send distinct rds 1..5 in one cycle, rr_ptr=0.
  - Required: ports carry (1,2), then (3,4), then (5); rr_ptr sequence is 2, 4, 0.
- Same-rd collision:
  - Stimulus: EU0 and EU1 both target rd=7.
  - Required: only EU0 is granted in the first arbitration cycle, EU1 in the next; in_ready[1]=0 for one cycle.
- Branch backpressure:
  - Stimulus: fill buffer 2 while rr_ptr selects ports for EUs 0 and 1, with EUs 0 and 1 refilled every cycle.
  - Required: wb_stall_branch=1 for at most 2 cycles, then EU2 is granted (fairness).
- Back-to-back streaming:
  - Stimulus: EU3 sends a new rd every cycle with no other traffic.
  - Required: in_ready[3] stays 1 and wr_en[0]=1 every cycle after the first.
